// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and
// transaction owner IDs.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Counter width that stays >= 1 bit even when the maximum value is 0.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// Counts consecutive data grants made while a fetch waits; once the limit is
// reached the fetch is forced through at the next arbitration.
module arb_starve_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_grant,
    input  logic if_pending,
    output logic force_if
);

    localparam int SW = cnt_width(STARVE_LIM);

    logic [SW-1:0] cnt;

    // if_pending is low while the fetch is idle, granted or in flight, which clears the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!if_pending) begin
            cnt <= '0;
        end else if (d_grant && (cnt != SW'(STARVE_LIM))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_if = (cnt == SW'(STARVE_LIM));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch
// and the data (load/store) port, one transaction outstanding at a time.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_valid,
    output logic [31:0]         if_rdata,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CW = cnt_width(MEM_LAT - 1);

    state_t        state;
    owner_t        owner;
    logic          squash;
    logic [CW-1:0] cnt;

    logic in_idle, grant_if, grant_d, if_busy, if_pending, force_if;

    assign in_idle  = (state == ST_IDLE);
    // Data wins unless the fetch has been starved; a flush vetoes the fetch this cycle.
    assign grant_if = in_idle & if_req & ~if_flush & (force_if | ~d_req);
    assign grant_d  = in_idle & d_req & ~grant_if;

    assign if_busy    = (~in_idle & (owner == OWN_IF)) | grant_if;
    assign if_pending = if_req & ~if_busy;

    arb_starve_counter #(
        .STARVE_LIM(STARVE_LIM)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .d_grant   (grant_d),
        .if_pending(if_pending),
        .force_if  (force_if)
    );

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            squash    <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            mem_req  <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (if_flush && !in_idle && (owner == OWN_IF)) begin
                squash <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_if || grant_d) begin
                        owner     <= grant_d ? OWN_D : OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= grant_d & d_we;
                        mem_be    <= grant_d ? d_be : '0;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CW'(MEM_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                        if (owner == OWN_D) begin
                            d_valid <= 1'b1;
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else if (!(squash || if_flush)) begin
                            // A flush arriving on the capture cycle still kills the fetch.
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata[31:0];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    squash <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;

    localparam int AW = 64, DW = 64, BW = 8, L = 2, SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, if_valid, if_stall;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          d_req, d_we, d_valid, d_stall;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_LIM(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          ifr;
        logic [63:0] ifa;
        bit          dr;
        logic [63:0] da;
        bit          em;
        logic [63:0] ea;
        bit          eiv;
        bit          edv;
    } vec_t;

    int          errs = 0, checks = 0, cyc = 0, rd_cycle = -1;
    logic [63:0] rd_val, tmp;
    vec_t        tv[17];

    // Reference model state (transaction level).
    bit          act, sq, own_d, gi, gd, ifr_on, dr_on, pflush;
    bit          e_mreq, e_ifv, e_dv, m_we;
    int          t0, nidle, starve, ng;
    logic [63:0] m_addr, m_wdata, l_d;
    logic [7:0]  m_be;
    logic [31:0] l_if;

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_0F0F_3C3C_C3C3;
    endfunction

    function automatic vec_t mk(bit ifr, logic [63:0] ifa, bit dr, logic [63:0] da,
                                bit em, logic [63:0] ea, bit eiv, bit edv);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.da = da;
        v.em = em; v.ea = ea; v.eiv = eiv; v.edv = edv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Start of a cycle: the memory returns data exactly L cycles after mem_req, garbage otherwise.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = (cyc == rd_cycle) ? rd_val : {$urandom, $urandom};
    endtask

    task automatic settle();
        @(negedge clk);
        if (mem_req) begin
            rd_cycle = cyc + L;
            rd_val   = data_of(mem_addr);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0; d_be = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_be"}, mem_be, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_d_valid"}, d_valid, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    task automatic do_reset();
        tick(); reset = 1; idle_inputs(); settle();
        tick(); reset = 0; settle();
        check_zero("rst");
        chk("rst_if_stall", if_stall, 0);
        chk("rst_d_stall", d_stall, 0);
    endtask

    initial begin
        reset = 1; idle_inputs();
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        tv[0]  = mk(1, 'h40, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 'h40, 0, 0, 1, 'h40, 0, 0);
        tv[2]  = tv[0];
        tv[3]  = tv[0];
        tv[4]  = mk(1, 'h40, 0, 0, 0, 0, 1, 0);
        tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tv[6]  = mk(1, 'h80, 1, 'h100, 0, 0, 0, 0);
        tv[7]  = mk(1, 'h80, 1, 'h100, 1, 'h100, 0, 0);
        tv[8]  = tv[6];
        tv[9]  = tv[6];
        tv[10] = mk(1, 'h80, 1, 'h100, 0, 0, 0, 1);
        tv[11] = mk(1, 'h80, 0, 0, 0, 0, 0, 0);
        tv[12] = mk(1, 'h80, 0, 0, 1, 'h80, 0, 0);
        tv[13] = tv[11];
        tv[14] = tv[11];
        tv[15] = mk(1, 'h80, 0, 0, 0, 0, 1, 0);
        tv[16] = tv[5];

        do_reset();

        // Single fetch, then simultaneous fetch + load.
        for (int i = 0; i < 17; i++) begin
            tick();
            if_req = tv[i].ifr; if_addr = tv[i].ifa;
            d_req = tv[i].dr; d_addr = tv[i].da; d_we = 0;
            settle();
            chk($sformatf("tv%0d_mem_req", i), mem_req, tv[i].em);
            if (tv[i].em) begin
                chk($sformatf("tv%0d_mem_addr", i), mem_addr, tv[i].ea);
                chk($sformatf("tv%0d_mem_we", i), mem_we, 0);
            end
            chk($sformatf("tv%0d_if_valid", i), if_valid, tv[i].eiv);
            chk($sformatf("tv%0d_d_valid", i), d_valid, tv[i].edv);
            chk($sformatf("tv%0d_if_stall", i), if_stall, tv[i].ifr & ~tv[i].eiv);
            chk($sformatf("tv%0d_d_stall", i), d_stall, tv[i].dr & ~tv[i].edv);
            if (tv[i].eiv) begin
                tmp = data_of(tv[i].ifa);
                chk($sformatf("tv%0d_if_rdata", i), if_rdata, tmp[31:0]);
            end
            if (tv[i].edv) chk($sformatf("tv%0d_d_rdata", i), d_rdata, data_of(tv[i].da));
        end

        // Store: enables and data reach memory, completion returns zero data.
        for (int k = 0; k < 6; k++) begin
            tick();
            d_req = (k < 5); d_we = 1; d_be = 8'h0F; d_addr = 'h600; d_wdata = 64'hDEADBEEF;
            settle();
            chk($sformatf("st%0d_mem_req", k), mem_req, k == 1);
            if (k == 1) begin
                chk("st_mem_we", mem_we, 1);
                chk("st_mem_be", mem_be, 8'h0F);
                chk("st_mem_addr", mem_addr, 'h600);
                chk("st_mem_wdata", mem_wdata, 64'hDEADBEEF);
            end
            chk($sformatf("st%0d_d_valid", k), d_valid, k == 4);
            if (k == 3) chk("st_d_rdata_hold", d_rdata, data_of('h100));
            if (k == 4) chk("st_d_rdata_zero", d_rdata, 0);
        end
        idle_inputs();

        // Reset during WAIT abandons the load; the late memory data is ignored.
        for (int k = 0; k < 7; k++) begin
            tick();
            d_req = (k < 2); d_we = 0; d_addr = 'h700;
            reset = (k == 2);
            settle();
            if (k == 1) begin
                chk("rw_mem_req", mem_req, 1);
                chk("rw_mem_addr", mem_addr, 'h700);
            end
            if (k == 3) check_zero("rw");
            if (k >= 3) begin
                chk($sformatf("rw%0d_d_valid", k), d_valid, 0);
                chk($sformatf("rw%0d_d_rdata", k), d_rdata, 0);
            end
        end
        reset = 0;

        // Flush while the fetch waits: no replay, no valid, next fetch normal.
        for (int k = 0; k < 11; k++) begin
            tick();
            if_req = (k < 10); if_addr = (k < 3) ? 'h400 : 'h500; if_flush = (k == 2);
            settle();
            chk($sformatf("fl%0d_mem_req", k), mem_req, (k == 1) || (k == 6));
            if (k == 6) chk("fl_mem_addr", mem_addr, 'h500);
            chk($sformatf("fl%0d_if_valid", k), if_valid, k == 9);
            if (k == 4) chk("fl_if_stall", if_stall, 1);
            if (k == 9) begin
                tmp = data_of('h500);
                chk("fl_if_rdata", if_rdata, tmp[31:0]);
            end
        end
        idle_inputs();

        // Starvation: both held high -> 4 data grants, 1 fetch, repeat.
        do_reset();
        ng = 0;
        for (int k = 0; k < 56; k++) begin
            tick();
            if_req = 1; if_addr = 'h200; d_req = 1; d_we = 0; d_addr = 'h300;
            settle();
            if (mem_req && ng < 10) begin
                chk($sformatf("sv_grant%0d", ng), mem_addr, (ng % 5 == 4) ? 64'h200 : 64'h300);
                ng++;
            end
        end
        chk("sv_grant_count", ng, 10);
        idle_inputs();

        // Random traffic against the reference model.
        do_reset();
        act = 0; sq = 0; own_d = 0; starve = 0; t0 = 0; nidle = cyc + 1;
        m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0; l_if = 0; l_d = 0;
        ifr_on = 0; dr_on = 0; pflush = 0;
        for (int n = 0; n < 2500; n++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if (pflush) begin
                if_addr = {$urandom, $urandom};
                ifr_on  = $urandom_range(0, 1);
            end
            if (!ifr_on && $urandom_range(0, 2) == 0) begin
                ifr_on = 1; if_addr = {$urandom, $urandom};
            end
            if (!dr_on && $urandom_range(0, 2) == 0) begin
                dr_on = 1; d_we = $urandom_range(0, 1); d_be = $urandom;
                d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            end
            if_req = ifr_on; d_req = dr_on;
            if_flush = ifr_on && ($urandom_range(0, 9) == 0);
            pflush = if_flush;
            settle();

            e_mreq = act && (cyc == t0 + 1);
            e_ifv  = act && !own_d && (cyc == t0 + L + 2) && !sq;
            e_dv   = act && own_d && (cyc == t0 + L + 2);
            if (e_ifv) begin tmp = data_of(m_addr); l_if = tmp[31:0]; end
            if (e_dv) l_d = m_we ? 64'd0 : data_of(m_addr);
            chk("rnd_mem_req", mem_req, e_mreq);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_we", mem_we, m_we);
            chk("rnd_mem_be", mem_be, m_be);
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
            chk("rnd_if_valid", if_valid, e_ifv);
            chk("rnd_d_valid", d_valid, e_dv);
            chk("rnd_if_rdata", if_rdata, l_if);
            chk("rnd_d_rdata", d_rdata, l_d);
            chk("rnd_if_stall", if_stall, if_req & ~e_ifv);
            chk("rnd_d_stall", d_stall, d_req & ~e_dv);
            if (if_valid) ifr_on = 0;
            if (d_valid) dr_on = 0;

            if (reset) begin
                act = 0; sq = 0; starve = 0; l_if = 0; l_d = 0;
                m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0; nidle = cyc + 1;
            end else begin
                if (act && !own_d && cyc >= t0 + 1 && cyc <= t0 + L + 1 && if_flush) sq = 1;
                if (cyc >= nidle) begin act = 0; sq = 0; end
                if (!if_req || (act && !own_d)) starve = 0;
                if (cyc >= nidle) begin
                    gi = if_req && !if_flush && ((starve == SL) || !d_req);
                    gd = d_req && !gi;
                    if (gi) starve = 0;
                    else if (gd && if_req && starve < SL) starve++;
                    if (gi || gd) begin
                        act = 1; own_d = gd; t0 = cyc; nidle = cyc + L + 3;
                        m_addr  = gd ? d_addr : if_addr;
                        m_we    = gd && d_we;
                        m_be    = gd ? d_be : 8'h00;
                        m_wdata = gd ? d_wdata : 64'd0;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
